keyboard_note_decoder: RTL
==========================

// Module: keyboard_note_decoder
// PURPOSE
//  Receives PS/2 set-2 scan codes and maps 25 note keys to freq_id 0..24.
//  Emits a one-cycle new_f strobe when a new note key is pressed.
//  Sits directly upstream of physics, which consumes freq_id and new_f.
// PARAMETERS
//  FILTER_LEN      8      ps2_clk glitch filter: consecutive equal samples required to change level
//  TIMEOUT_CYCLES  65000  clock cycles without a filtered ps2_clk edge mid-frame before abort (~1 ms at 65 MHz)
// PORTS
//  clock       in   1  system clock
//  reset       in   1  synchronous, active-high reset
//  ps2_clk     in   1  raw PS/2 clock, asynchronous
//  ps2_data    in   1  raw PS/2 data, asynchronous
//  freq_id     out  5  last pressed note, 0 = lowest, 24 = highest
//  new_f       out  1  one-cycle strobe; freq_id is valid in the same cycle
//  key_held    out  1  1 while the key for freq_id is down
//  parity_err  out  1  one-cycle strobe on a bad-parity frame (PS2_PARITY_CHECK_EN only)
// BEHAVIOUR
//  Reset values: freq_id=0, new_f=0, key_held=0, parity_err=0; FSM=IDLE; break_pend=0; ext_pend=0.
//  Input path:
//   - 2-flop synchroniser on ps2_clk and ps2_data.
//   - ps2_clk passes through the FILTER_LEN filter; a falling edge of the filtered clock is fall_e.
//  Frame FSM (advances only on fall_e, except on timeout):
//   - IDLE: data=0 -> DATA with bit count 0; data=1 -> stay in IDLE.
//   - DATA: shift data in LSB first; after the 8th bit -> PARITY.
//   - PARITY: latch the parity bit -> STOP.
//   - STOP: data=1 -> byte valid; data=0 -> frame dropped. Either way -> IDLE.
//  Timeout: TIMEOUT_CYCLES consecutive cycles in DATA, PARITY or STOP with no fall_e
//   -> IDLE, partial byte discarded, no outputs changed.
//  Latency: byte_valid is registered 1 cycle after the stop-bit fall_e; outputs update 1 cycle later (fall_e+2).
//  Byte decode (on byte_valid):
//   - E0: set ext_pend.
//   - F0: set break_pend.
//   - Any other code with ext_pend=1: ignore the code; clear ext_pend and break_pend.
//   - Mapped code, break_pend=0 (make):
//       - If key_held=1 and the code maps to the current freq_id: typematic repeat, no strobe.
//       - Otherwise: freq_id<=map, key_held<=1, new_f=1 for one cycle.
//   - Mapped code, break_pend=1 (break): if the code maps to the current freq_id then key_held<=0.
//     A break for any other key is ignored.
//   - Unmapped code: no effect.
//   - break_pend clears after any non-F0 byte.
//  Map (hex): 1A=0, 1B=1, 22=2, 23=3, 21=4, 2A=5, 34=6, 32=7, 33=8, 31=9, 3B=10, 3A=11,
//   15=12, 1E=13, 1D=14, 26=15, 24=16, 2D=17, 2E=18, 2C=19, 36=20, 35=21, 3D=22, 3C=23, 43=24.
//  freq_id is never outside 0..24. new_f never asserts on two consecutive cycles.
//  Reset mid-frame: abandons the frame and clears pending flags; the next frame decodes normally.
// CONFIGURATION
//  PS2_PARITY_CHECK_EN:
//   - Defined: a frame whose 8 data bits plus parity bit are not odd parity is dropped at STOP,
//     and parity_err pulses for 1 cycle at fall_e+2.
//   - Not defined: the parity bit is ignored and parity_err is tied to 0.
// TESTING
//  1. Frame 1A, clean -> freq_id=0, new_f high for exactly 1 cycle at fall_e+2, key_held=1.
//  2. 43, then 43 again (typematic) -> one new_f only; freq_id=24 after both frames.
//  3. 15, then F0 15 -> freq_id=12, key_held goes 1 then 0; no new_f for the break.
//  4. 1A, 3A, then F0 1A -> freq_id=11, key_held stays 1; then F0 3A -> key_held=0.
//  5. E0 1A, then unmapped 5A -> no new_f, freq_id unchanged; then 22 -> freq_id=2, new_f pulse.
//  6. 4 bits of 1A then a stall of TIMEOUT_CYCLES+1 -> FSM back in IDLE; a full 1B frame then gives freq_id=1.
//  7. PS2_PARITY_CHECK_EN defined, 1A sent with even parity -> parity_err 1-cycle pulse, no new_f.

Source files
------------

// File: rtl/keyboard_note_decoder.sv
// PS/2 set-2 scan-code receiver that maps 25 note keys to freq_id 0..24 with a new_f strobe.
// Optional odd-parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module keyboard_note_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 65000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [4:0] freq_id,
    output logic       new_f,
    output logic       key_held,
    output logic       parity_err
);

    // state     | meaning
    // ST_IDLE   | waiting for a start bit (data low on fall_e)
    // ST_DATA   | shifting in 8 data bits, LSB first
    // ST_PARITY | sampling the parity bit
    // ST_STOP   | sampling the stop bit, byte valid if high
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FLT_LOAD = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          clk_f;
    logic [FW-1:0] flt_cnt;
    logic          fall_e;

    state_t        state, state_nx;
    logic [7:0]    shift;
    logic [2:0]    bit_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          byte_valid;
    logic          ext_pend, break_pend;
    logic          map_hit;
    logic [4:0]    map_id;

    // The filtered level only flips after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            dat_s1  <= 1'b1;
            dat_s2  <= 1'b1;
            clk_f   <= 1'b1;
            flt_cnt <= FLT_LOAD;
            fall_e  <= 1'b0;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
            fall_e <= 1'b0;
            if (clk_s2 == clk_f) begin
                flt_cnt <= FLT_LOAD;
            end else if (flt_cnt == '0) begin
                clk_f   <= clk_s2;
                flt_cnt <= FLT_LOAD;
                fall_e  <= clk_f;
            end else begin
                flt_cnt <= flt_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (fall_e) begin
            case (state)
                ST_IDLE:   if (!dat_s2) state_nx = ST_DATA;
                ST_DATA:   if (bit_cnt == 3'd7) state_nx = ST_PARITY;
                ST_PARITY: state_nx = ST_STOP;
                default:   state_nx = ST_IDLE;
            endcase
        end else if (state != ST_IDLE && tmo_cnt == '0) begin
            state_nx = ST_IDLE;
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    logic par_bit;
    logic par_fail;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            shift      <= '0;
            bit_cnt    <= '0;
            tmo_cnt    <= TMO_LOAD;
            byte_valid <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            par_bit    <= 1'b0;
            par_fail   <= 1'b0;
`endif
        end else begin
            byte_valid <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            par_fail   <= 1'b0;
`endif
            if (fall_e || state == ST_IDLE) tmo_cnt <= TMO_LOAD;
            else if (tmo_cnt != '0)         tmo_cnt <= tmo_cnt - 1'b1;
            if (fall_e) begin
                case (state)
                    ST_IDLE: bit_cnt <= '0;
                    ST_DATA: begin
                        shift   <= {dat_s2, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                        par_bit <= dat_s2;
`endif
                    end
                    default: begin
`ifdef PS2_PARITY_CHECK_EN
                        if (dat_s2) begin
                            if (^{shift, par_bit}) byte_valid <= 1'b1;
                            else                   par_fail   <= 1'b1;
                        end
`else
                        byte_valid <= dat_s2;
`endif
                    end
                endcase
            end
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    always_ff @(posedge clock) begin
        if (reset) parity_err <= 1'b0;
        else       parity_err <= par_fail;
    end
`else
    assign parity_err = 1'b0;
`endif

    always_comb begin
        map_hit = 1'b1;
        map_id  = 5'd0;
        case (shift)
            8'h1A: map_id = 5'd0;
            8'h1B: map_id = 5'd1;
            8'h22: map_id = 5'd2;
            8'h23: map_id = 5'd3;
            8'h21: map_id = 5'd4;
            8'h2A: map_id = 5'd5;
            8'h34: map_id = 5'd6;
            8'h32: map_id = 5'd7;
            8'h33: map_id = 5'd8;
            8'h31: map_id = 5'd9;
            8'h3B: map_id = 5'd10;
            8'h3A: map_id = 5'd11;
            8'h15: map_id = 5'd12;
            8'h1E: map_id = 5'd13;
            8'h1D: map_id = 5'd14;
            8'h26: map_id = 5'd15;
            8'h24: map_id = 5'd16;
            8'h2D: map_id = 5'd17;
            8'h2E: map_id = 5'd18;
            8'h2C: map_id = 5'd19;
            8'h36: map_id = 5'd20;
            8'h35: map_id = 5'd21;
            8'h3D: map_id = 5'd22;
            8'h3C: map_id = 5'd23;
            8'h43: map_id = 5'd24;
            default: map_hit = 1'b0;
        endcase
    end

    // Extended (E0-prefixed) codes are swallowed so arrow/nav keys never play notes.
    always_ff @(posedge clock) begin
        if (reset) begin
            freq_id    <= '0;
            new_f      <= 1'b0;
            key_held   <= 1'b0;
            ext_pend   <= 1'b0;
            break_pend <= 1'b0;
        end else begin
            new_f <= 1'b0;
            if (byte_valid) begin
                if (shift == 8'hE0) begin
                    ext_pend   <= 1'b1;
                    break_pend <= 1'b0;
                end else if (shift == 8'hF0) begin
                    break_pend <= 1'b1;
                end else begin
                    break_pend <= 1'b0;
                    if (ext_pend) begin
                        ext_pend <= 1'b0;
                    end else if (map_hit) begin
                        if (!break_pend) begin
                            if (!(key_held && map_id == freq_id)) begin
                                freq_id  <= map_id;
                                key_held <= 1'b1;
                                new_f    <= 1'b1;
                            end
                        end else if (map_id == freq_id) begin
                            key_held <= 1'b0;
                        end
                    end
                end
            end
        end
    end

endmodule
